// File: rtl/shift_tx_4.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and sends it one bit per clock with a frame qualifier and a last-bit pulse.
module shift_tx_4 #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serial_out_q, serial_out_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             accept;
  logic [WIDTH-1:0] sh_shifted;
  logic             out_bit;

  // Ready in the last-bit cycle lets a new word follow with no idle gap.
  assign load_ready = !reset && ((state_q == IDLE) || (cnt_q == LAST));
  assign accept     = load_valid && load_ready;
  assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (accept) begin
            sh_d = load_data;
          end else begin
            sh_d    = sh_shifted;
            state_d = IDLE;
          end
        end else begin
          sh_d  = sh_shifted;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next state so they are registered yet aligned with it.
  always_comb begin
    out_bit      = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
    serial_out_d = (state_d == SHIFT) && out_bit;
    frame_d      = (state_d == SHIFT);
    done_d       = (state_d == SHIFT) && (cnt_d == LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      serial_out_q <= 1'b0;
      frame_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      serial_out_q <= serial_out_d;
      frame_q      <= frame_d;
      done_q       <= done_d;
    end
  end

  assign serial_out = serial_out_q;
  assign frame      = frame_q;
  assign done       = done_q;

endmodule
